// File: rtl/serv_dbus_aligner_pkg.sv
// serv_dbus_aligner_pkg
//   Shared types and helpers for the SERV data-bus aligner.
//   - state_t     : aligner FSM state encodings
//   - WORD_BYTES  : bytes per Wishbone word (address step to the upper word)
//   - calc_split  : 1 when a request at byte offset k with enables sel
//                   spills into the next word
package serv_dbus_aligner_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic calc_split(input logic [3:0] sel, input logic [1:0] k);
    logic [7:0] s;
    s = {4'b0000, sel} << k;
    return |s[7:4];
  endfunction

endpackage

// File: rtl/serv_dbus_lane_shift.sv
// serv_dbus_lane_shift
//   Purely combinational byte-lane steering for misaligned accesses.
//   Ports:
//     k          in   byte offset of the access within its word
//     sel        in   byte enables relative to the byte address
//     dat        in   store data, byte 0 in [7:0]
//     rdt_hi     in   upper word of read data (zero for single-word loads)
//     rdt_lo     in   lower word of read data
//     sel_ext    out  enables spread across two words, {hi, lo}
//     dat_ext    out  store data spread across two words, {hi, lo}
//     rdt_merged out  read data realigned to byte 0
module serv_dbus_lane_shift (
  input  logic [1:0]  k,
  input  logic [3:0]  sel,
  input  logic [31:0] dat,
  input  logic [31:0] rdt_hi,
  input  logic [31:0] rdt_lo,
  output logic [7:0]  sel_ext,
  output logic [63:0] dat_ext,
  output logic [31:0] rdt_merged
);

  always_comb begin
    sel_ext    = {4'b0000, sel} << k;
    dat_ext    = {32'h0000_0000, dat} << {k, 3'b000};
    rdt_merged = 32'({rdt_hi, rdt_lo} >> {k, 3'b000});
  end

endmodule

// File: rtl/serv_dbus_aligner.sv
// serv_dbus_aligner
//   Aligns byte-addressed SERV data-bus loads/stores onto a word-wide
//   Wishbone port. Accesses crossing a word boundary are issued as two
//   word transactions (base, base+4) and load data is merged back.
//   Build option: define SERV_DBUS_MISALIGN_EN to enable split/merge;
//   without it every access is one unshifted word access at the base.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     i_dbus_adr/dat/sel/we/cyc      core request (held until o_dbus_ack)
//     o_dbus_rdt, o_dbus_ack         load data (byte 0 aligned), completion
//     o_wb_dbus_adr/dat/sel/we/cyc   Wishbone request (all registered)
//     i_wb_dbus_rdt, i_wb_dbus_ack   Wishbone response
module serv_dbus_aligner
  import serv_dbus_aligner_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [AW-1:0] o_wb_dbus_adr,
  output logic [31:0]   o_wb_dbus_dat,
  output logic [3:0]    o_wb_dbus_sel,
  output logic          o_wb_dbus_we,
  output logic          o_wb_dbus_cyc,
  input  logic [31:0]   i_wb_dbus_rdt,
  input  logic          i_wb_dbus_ack
);

  state_t      state;
  logic        we_q;
  logic [3:0]  cap_sel_lo;
  logic [31:0] cap_dat_lo;
  logic [31:0] rdt_done;
  logic        lo_split;
  logic        go_hi;
  logic        finish;

`ifdef SERV_DBUS_MISALIGN_EN
  logic [1:0]    k_q;
  logic [1:0]    k_mux;
  logic [AW-1:0] base_q;
  logic [3:0]    sel_hi_q;
  logic [31:0]   dat_hi_q;
  logic          split_q;
  logic [31:0]   lo_q;
  logic [7:0]    sel_ext;
  logic [63:0]   dat_ext;
  logic [31:0]   rdt_hi;
  logic [31:0]   rdt_lo;

  // One shifter serves both directions: in IDLE it steers the incoming
  // request by the live offset, afterwards it merges read data by the
  // captured offset.
  always_comb begin
    k_mux      = (state == ST_IDLE) ? i_dbus_adr[1:0] : k_q;
    rdt_hi     = (state == ST_HI) ? i_wb_dbus_rdt : '0;
    rdt_lo     = (state == ST_HI) ? lo_q : i_wb_dbus_rdt;
    cap_sel_lo = sel_ext[3:0];
    cap_dat_lo = dat_ext[31:0];
    lo_split   = split_q;
  end

  serv_dbus_lane_shift u_lane_shift (
    .k          (k_mux),
    .sel        (i_dbus_sel),
    .dat        (i_dbus_dat),
    .rdt_hi     (rdt_hi),
    .rdt_lo     (rdt_lo),
    .sel_ext    (sel_ext),
    .dat_ext    (dat_ext),
    .rdt_merged (rdt_done)
  );
`else
  logic [1:0] adr_lsb_unused;

  always_comb begin
    cap_sel_lo     = i_dbus_sel;
    cap_dat_lo     = i_dbus_dat;
    rdt_done       = i_wb_dbus_rdt;
    lo_split       = 1'b0;
    adr_lsb_unused = i_dbus_adr[1:0];
  end
`endif

  always_comb begin
    go_hi  = (state == ST_LO) && i_wb_dbus_ack && lo_split;
    finish = i_wb_dbus_ack &&
             (((state == ST_LO) && !lo_split) || (state == ST_HI));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      o_dbus_rdt    <= '0;
      o_dbus_ack    <= 1'b0;
      o_wb_dbus_adr <= '0;
      o_wb_dbus_dat <= '0;
      o_wb_dbus_sel <= '0;
      o_wb_dbus_we  <= 1'b0;
      o_wb_dbus_cyc <= 1'b0;
`ifdef SERV_DBUS_MISALIGN_EN
      k_q      <= '0;
      base_q   <= '0;
      sel_hi_q <= '0;
      dat_hi_q <= '0;
      split_q  <= 1'b0;
      lo_q     <= '0;
`endif
    end else begin
      o_dbus_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_dbus_cyc) begin
            we_q          <= i_dbus_we;
            o_wb_dbus_adr <= {i_dbus_adr[AW-1:2], 2'b00};
            o_wb_dbus_sel <= cap_sel_lo;
            o_wb_dbus_dat <= cap_dat_lo;
            o_wb_dbus_we  <= i_dbus_we;
            o_wb_dbus_cyc <= 1'b1;
            state         <= ST_LO;
`ifdef SERV_DBUS_MISALIGN_EN
            k_q      <= i_dbus_adr[1:0];
            base_q   <= {i_dbus_adr[AW-1:2], 2'b00};
            sel_hi_q <= sel_ext[7:4];
            dat_hi_q <= dat_ext[63:32];
            split_q  <= calc_split(i_dbus_sel, i_dbus_adr[1:0]);
`endif
          end
        end
        // The core drops cyc the cycle after ack; not sampling it here
        // keeps that trailing cyc from restarting a transaction.
        ST_DONE: state <= ST_IDLE;
        default: ;
      endcase

`ifdef SERV_DBUS_MISALIGN_EN
      if (go_hi) begin
        lo_q          <= i_wb_dbus_rdt;
        o_wb_dbus_adr <= base_q + AW'(WORD_BYTES);
        o_wb_dbus_sel <= sel_hi_q;
        o_wb_dbus_dat <= dat_hi_q;
        state         <= ST_HI;
      end
`endif

      if (finish) begin
        o_wb_dbus_cyc <= 1'b0;
        o_wb_dbus_adr <= '0;
        o_wb_dbus_sel <= '0;
        o_wb_dbus_dat <= '0;
        o_wb_dbus_we  <= 1'b0;
        o_dbus_ack    <= 1'b1;
        if (!we_q) o_dbus_rdt <= rdt_done;
        state <= ST_DONE;
      end
    end
  end

endmodule
